// File: rtl/spi_slave_tx_pkg.sv
// Shared definitions for the MCU SPI link: transmit FSM encodings and the
// default word width used by both the ADC receive path and this transmitter.
package spi_slave_tx_pkg;

  localparam int SPI_WORD_BITS = 16;

  typedef enum logic [1:0] {
    SPI_TX_IDLE  = 2'd0,
    SPI_TX_SHIFT = 2'd1,
    SPI_TX_HOLD  = 2'd2
  } spi_tx_state_t;

endpackage

// File: rtl/spi_input_sync.sv
// Multi-flop synchroniser for one asynchronous SPI pin, with a previous-value
// flop so rise/fall are derived purely from synchronised samples.
module spi_input_sync #(
  parameter int   STAGES      = 2,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic clock,
  input  logic rstn,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      chain <= {STAGES{RESET_LEVEL}};
      prev  <= RESET_LEVEL;
    end else begin
      chain <= {chain[STAGES-2:0], async_in};
      prev  <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/spi_slave_tx.sv
// SPI mode-0 slave transmitter (MISO): shifts the holding word out MSB first
// while the MCU holds NSS low, all in the system clock domain.
module spi_slave_tx
  import spi_slave_tx_pkg::*;
#(
  parameter int WORD_BITS   = SPI_WORD_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clock,
  input  logic                 rstn,
  input  logic                 spi_nss,
  input  logic                 spi_clock_in,
  output logic                 spi_data_out,
  input  logic [WORD_BITS-1:0] data_in,
  input  logic                 data_load,
  output logic                 busy,
  output logic                 tx_done,
  output logic                 tx_abort,
  output logic                 stale
);

  localparam int CNT_W = $clog2(WORD_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_BITS - 1);

  spi_tx_state_t        state;
  logic [WORD_BITS-1:0] holding;
  logic [WORD_BITS-1:0] shift;
  logic [CNT_W-1:0]     bit_count;
  logic [SYNC_STAGES:0] warm;
  logic                 armed;

  logic nss_level, nss_rise, nss_fall;
  logic sclk_level_unused, sclk_rise, sclk_fall;
  logic start;
  logic [WORD_BITS-1:0] next_word;

  spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_LEVEL(1'b1)) u_nss_sync (
    .clock    (clock),
    .rstn     (rstn),
    .async_in (spi_nss),
    .level    (nss_level),
    .rise     (nss_rise),
    .fall     (nss_fall)
  );

  spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_LEVEL(1'b0)) u_sclk_sync (
    .clock    (clock),
    .rstn     (rstn),
    .async_in (spi_clock_in),
    .level    (sclk_level_unused),
    .rise     (sclk_rise),
    .fall     (sclk_fall)
  );

  // The NSS chain resets high, so a pin held low through reset shows up as a
  // fall; only arm once the chain holds real samples and NSS is seen high.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      warm  <= '0;
      armed <= 1'b0;
    end else begin
      warm <= {warm[SYNC_STAGES-1:0], 1'b1};
      if (warm[SYNC_STAGES] && nss_level)
        armed <= 1'b1;
    end
  end

  assign start     = armed & nss_fall;
  assign next_word = data_load ? data_in : holding;

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state        <= SPI_TX_IDLE;
      holding      <= '0;
      shift        <= '0;
      bit_count    <= '0;
      spi_data_out <= 1'b0;
      busy         <= 1'b0;
      tx_done      <= 1'b0;
      tx_abort     <= 1'b0;
      stale        <= 1'b1;
    end else begin
      tx_done  <= 1'b0;
      tx_abort <= 1'b0;
      if (data_load) begin
        holding <= data_in;
        stale   <= 1'b0;
      end
      case (state)
        SPI_TX_IDLE: begin
          spi_data_out <= 1'b0;
          if (start) begin
            shift        <= next_word;
            spi_data_out <= next_word[WORD_BITS-1];
            bit_count    <= '0;
            busy         <= 1'b1;
            stale        <= ~data_load;
            state        <= SPI_TX_SHIFT;
          end
        end
        SPI_TX_SHIFT: begin
          if (nss_rise) begin
            tx_abort     <= 1'b1;
            busy         <= 1'b0;
            spi_data_out <= 1'b0;
            state        <= SPI_TX_IDLE;
          end else if (sclk_rise) begin
            bit_count <= bit_count + 1'b1;
            if (bit_count == LAST_BIT) begin
              tx_done      <= 1'b1;
              spi_data_out <= 1'b0;
              state        <= SPI_TX_HOLD;
            end
          end else if (sclk_fall) begin
            shift        <= {shift[WORD_BITS-2:0], 1'b0};
            spi_data_out <= shift[WORD_BITS-2];
          end
        end
        SPI_TX_HOLD: begin
          spi_data_out <= 1'b0;
          if (nss_rise) begin
            busy  <= 1'b0;
            state <= SPI_TX_IDLE;
          end
        end
        default: state <= SPI_TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_tx.sv
// Directed bench for spi_slave_tx: mode-0 master model sampling MISO at each
// SCLK rise, with pulse counters watching tx_done / tx_abort.
module tb_spi_slave_tx;

  localparam int SYNC = 2;

  logic        clock = 1'b0;
  logic        rstn = 1'b0;
  logic        spi_nss = 1'b1;
  logic        spi_clock_in = 1'b0;
  logic        spi_data_out;
  logic [15:0] data_in = '0;
  logic        data_load = 1'b0;
  logic        busy, tx_done, tx_abort, stale;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int abort_cnt = 0;

  spi_slave_tx #(.WORD_BITS(16), .SYNC_STAGES(SYNC)) dut (
    .clock        (clock),
    .rstn         (rstn),
    .spi_nss      (spi_nss),
    .spi_clock_in (spi_clock_in),
    .spi_data_out (spi_data_out),
    .data_in      (data_in),
    .data_load    (data_load),
    .busy         (busy),
    .tx_done      (tx_done),
    .tx_abort     (tx_abort),
    .stale        (stale)
  );

  // 14 ns period; every bench delay is a multiple of 14 so stimulus and
  // sampling land on falling clock edges.
  always #7 clock = ~clock;

  always @(posedge clock) begin
    if (tx_done) done_cnt++;
    if (tx_abort) abort_cnt++;
  end

  task automatic load_word(input logic [15:0] val);
    data_in   = val;
    data_load = 1'b1;
    #14;
    data_load = 1'b0;
  endtask

  // SCLK half period 126 ns (9 clocks, just under 4 MHz).
  task automatic spi_xfer(input int nbits, input int load_bit, input logic [15:0] load_val,
                          input bit load_at_fall, output logic [31:0] rx,
                          output bit stale_lo, output bit stale_hi, output bit busy_mid);
    rx = '0;
    stale_lo = 1'b0;
    stale_hi = 1'b0;
    busy_mid = 1'b0;
    spi_nss = 1'b0;
    if (load_at_fall) begin
      #(14 * SYNC);
      load_word(load_val);
      #(252 - 14 * SYNC - 14);
    end else begin
      #252;
    end
    for (int i = 0; i < nbits; i++) begin
      rx = {rx[30:0], spi_data_out};
      if (stale) stale_hi = 1'b1; else stale_lo = 1'b1;
      if (busy) busy_mid = 1'b1;
      spi_clock_in = 1'b1;
      #126;
      spi_clock_in = 1'b0;
      if (i == load_bit) begin
        #56;
        load_word(load_val);
        #56;
      end else begin
        #126;
      end
    end
    spi_nss = 1'b1;
    #196;
  endtask

  task automatic test_reset;
    #70;
    checks++; if (spi_data_out !== 1'b0) begin failures++; $display("[TB] FAIL reset_miso got=%b exp=0", spi_data_out); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (tx_done !== 1'b0 || tx_abort !== 1'b0) begin failures++; $display("[TB] FAIL reset_pulses got=%b%b exp=00", tx_done, tx_abort); end
    checks++; if (stale !== 1'b1) begin failures++; $display("[TB] FAIL reset_stale got=%b exp=1", stale); end
    rstn = 1'b1;
    #140;
  endtask

  task automatic test_basic;
    logic [31:0] rx;
    bit slo, shi, bmid;
    int d0, a0;
    load_word(16'hA5C3);
    #28;
    checks++; if (stale !== 1'b0) begin failures++; $display("[TB] FAIL load_clears_stale got=%b exp=0", stale); end
    d0 = done_cnt; a0 = abort_cnt;
    spi_xfer(16, -1, 16'h0, 1'b0, rx, slo, shi, bmid);
    checks++; if (rx[15:0] !== 16'hA5C3) begin failures++; $display("[TB] FAIL basic_word got=%h exp=a5c3", rx[15:0]); end
    checks++; if (done_cnt - d0 !== 1) begin failures++; $display("[TB] FAIL basic_done got=%0d exp=1", done_cnt - d0); end
    checks++; if (abort_cnt - a0 !== 0) begin failures++; $display("[TB] FAIL basic_abort got=%0d exp=0", abort_cnt - a0); end
    checks++; if (bmid !== 1'b1) begin failures++; $display("[TB] FAIL basic_busy_mid got=%b exp=1", bmid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL basic_busy_end got=%b exp=0", busy); end
    checks++; if (stale !== 1'b1) begin failures++; $display("[TB] FAIL basic_stale got=%b exp=1", stale); end
  endtask

  task automatic test_resend_and_midload;
    logic [31:0] rx;
    bit slo, shi, bmid;
    spi_xfer(16, -1, 16'h0, 1'b0, rx, slo, shi, bmid);
    checks++; if (rx[15:0] !== 16'hA5C3) begin failures++; $display("[TB] FAIL resend_word got=%h exp=a5c3", rx[15:0]); end
    checks++; if (slo !== 1'b0) begin failures++; $display("[TB] FAIL resend_stale_low_seen got=%b exp=0", slo); end
    spi_xfer(16, 7, 16'h1234, 1'b0, rx, slo, shi, bmid);
    checks++; if (rx[15:0] !== 16'hA5C3) begin failures++; $display("[TB] FAIL midload_current got=%h exp=a5c3", rx[15:0]); end
    checks++; if (stale !== 1'b0) begin failures++; $display("[TB] FAIL midload_stale got=%b exp=0", stale); end
    spi_xfer(16, -1, 16'h0, 1'b0, rx, slo, shi, bmid);
    checks++; if (rx[15:0] !== 16'h1234) begin failures++; $display("[TB] FAIL midload_next got=%h exp=1234", rx[15:0]); end
  endtask

  task automatic test_abort;
    logic [31:0] rx;
    bit slo, shi, bmid;
    int d0, a0;
    d0 = done_cnt; a0 = abort_cnt;
    spi_xfer(7, -1, 16'h0, 1'b0, rx, slo, shi, bmid);
    checks++; if (rx[6:0] !== 7'h09) begin failures++; $display("[TB] FAIL abort_bits got=%h exp=09", rx[6:0]); end
    checks++; if (abort_cnt - a0 !== 1) begin failures++; $display("[TB] FAIL abort_pulse got=%0d exp=1", abort_cnt - a0); end
    checks++; if (done_cnt - d0 !== 0) begin failures++; $display("[TB] FAIL abort_no_done got=%0d exp=0", done_cnt - d0); end
    checks++; if (spi_data_out !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL abort_idle got miso=%b busy=%b exp=0,0", spi_data_out, busy); end
    spi_xfer(16, -1, 16'h0, 1'b0, rx, slo, shi, bmid);
    checks++; if (rx[15:0] !== 16'h1234) begin failures++; $display("[TB] FAIL abort_retry got=%h exp=1234", rx[15:0]); end
  endtask

  task automatic test_overrun;
    logic [31:0] rx;
    bit slo, shi, bmid;
    int d0, a0;
    load_word(16'hC3E1);
    #28;
    d0 = done_cnt; a0 = abort_cnt;
    spi_xfer(20, -1, 16'h0, 1'b0, rx, slo, shi, bmid);
    checks++; if (rx[19:0] !== 20'hC3E10) begin failures++; $display("[TB] FAIL overrun_bits got=%h exp=c3e10", rx[19:0]); end
    checks++; if (done_cnt - d0 !== 1) begin failures++; $display("[TB] FAIL overrun_done got=%0d exp=1", done_cnt - d0); end
    checks++; if (abort_cnt - a0 !== 0) begin failures++; $display("[TB] FAIL overrun_abort got=%0d exp=0", abort_cnt - a0); end
  endtask

  task automatic test_load_at_fall;
    logic [31:0] rx;
    bit slo, shi, bmid;
    spi_xfer(16, -1, 16'hFFFF, 1'b1, rx, slo, shi, bmid);
    checks++; if (rx[15:0] !== 16'hFFFF) begin failures++; $display("[TB] FAIL fall_load_word got=%h exp=ffff", rx[15:0]); end
    checks++; if (stale !== 1'b0) begin failures++; $display("[TB] FAIL fall_load_stale got=%b exp=0", stale); end
    checks++; if (shi !== 1'b0) begin failures++; $display("[TB] FAIL fall_load_stale_seen got=%b exp=0", shi); end
  endtask

  task automatic test_reset_midtransfer;
    logic [31:0] rx;
    bit slo, shi, bmid, any_busy, any_data;
    int d0, a0;
    spi_nss = 1'b0;
    #252;
    for (int i = 0; i < 5; i++) begin
      spi_clock_in = 1'b1; #126; spi_clock_in = 1'b0; #126;
    end
    rstn = 1'b0;
    #28;
    checks++; if (busy !== 1'b0 || spi_data_out !== 1'b0) begin failures++; $display("[TB] FAIL midreset_outputs got busy=%b miso=%b exp=0,0", busy, spi_data_out); end
    checks++; if (stale !== 1'b1) begin failures++; $display("[TB] FAIL midreset_stale got=%b exp=1", stale); end
    #28;
    rstn = 1'b1;
    d0 = done_cnt; a0 = abort_cnt;
    any_busy = 1'b0; any_data = 1'b0;
    #252;
    for (int i = 0; i < 8; i++) begin
      if (busy) any_busy = 1'b1;
      if (spi_data_out) any_data = 1'b1;
      spi_clock_in = 1'b1; #126; spi_clock_in = 1'b0; #126;
    end
    spi_nss = 1'b1;
    #196;
    checks++; if (any_busy !== 1'b0 || any_data !== 1'b0) begin failures++; $display("[TB] FAIL held_nss_no_start got busy=%b miso=%b exp=0,0", any_busy, any_data); end
    checks++; if (done_cnt - d0 !== 0 || abort_cnt - a0 !== 0) begin failures++; $display("[TB] FAIL held_nss_pulses got done=%0d abort=%0d exp=0,0", done_cnt - d0, abort_cnt - a0); end
    spi_xfer(16, -1, 16'h0, 1'b0, rx, slo, shi, bmid);
    checks++; if (rx[15:0] !== 16'h0000) begin failures++; $display("[TB] FAIL post_reset_word got=%h exp=0000", rx[15:0]); end
    checks++; if (done_cnt - d0 !== 1) begin failures++; $display("[TB] FAIL post_reset_done got=%0d exp=1", done_cnt - d0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_resend_and_midload();
    test_abort();
    test_overrun();
    test_load_at_fall();
    test_reset_midtransfer();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
